shift_wb_stage: RTL and testbench

SHIFT_WB_STAGE -- requirements
Module: shift_wb_stage

---
 rtl/cpu16_pkg.sv | 16 +
 rtl/skid_buf2.sv | 70 +++++++
 rtl/shift_wb_stage.sv | 79 +++++++
 tb/tb_shift_wb_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared widths and the writeback entry record for the 16-bit core.
package cpu16_pkg;

  localparam int unsigned CPU_WIDTH = 16;
  localparam int unsigned CPU_RDW   = 4;
  localparam int unsigned STALL_W   = 16;

  // Writeback entry as held in the shift writeback stage at the core widths.
  typedef struct packed {
    logic [CPU_WIDTH-1:0] result;
    logic [CPU_RDW-1:0]   rd;
    logic                 z;
    logic                 n;
  } wb_entry_t;

endpackage : cpu16_pkg

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer with valid/ready on both sides.
// Head entry is always slot 0; slot 1 holds the younger entry when full.
module skid_buf2 #(
  parameter int unsigned PW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic [1:0]    cnt_q, cnt_d;
  logic [PW-1:0] e0_q, e0_d;
  logic [PW-1:0] e1_q, e1_d;
  logic          push;
  logic          pop;

  // Handshake and output presentation; payload forced to zero when empty.
  always_comb begin
    in_ready  = rst_n && (cnt_q != 2'd2);
    out_valid = (cnt_q != 2'd0);
    out_data  = out_valid ? e0_q : '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next occupancy and slot contents; flush empties the buffer outright.
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop) begin
      e0_d = e1_q;
    end
    if (push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
        e0_d = in_data;
      end else begin
        e1_d = in_data;
      end
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      cnt_d = 2'd0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

endmodule : skid_buf2

// File: rtl/shift_wb_stage.sv
// Writeback stage for SRA shifter results: flags computed on entry,
// buffered two deep, with a saturating count of output-stall cycles.
module shift_wb_stage
  import cpu16_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned RDW   = CPU_RDW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_result,
  input  logic [RDW-1:0]     in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [RDW-1:0]     out_rd,
  output logic               out_z,
  output logic               out_n,
  output logic [STALL_W-1:0] stall_cnt
);

  // Entry record at this instance's widths (matches wb_entry_t at defaults).
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RDW-1:0]   rd;
    logic             z;
    logic             n;
  } entry_t;

  localparam int unsigned PW = $bits(entry_t);

  entry_t                 in_entry;
  entry_t                 out_entry;
  logic   [STALL_W-1:0]   stall_q;

  // Flags are derived once at push time and travel with the entry.
  always_comb begin
    in_entry.result = in_result;
    in_entry.rd     = in_rd;
    in_entry.z      = (in_result == '0);
    in_entry.n      = in_result[WIDTH-1];
  end

  skid_buf2 #(
    .PW(PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  // Unpack the head entry onto the writeback ports.
  always_comb begin
    out_result = out_entry.result;
    out_rd     = out_entry.rd;
    out_z      = out_entry.z;
    out_n      = out_entry.n;
    stall_cnt  = stall_q;
  end

  // Saturating stall counter; flush leaves it alone, reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

endmodule : shift_wb_stage

// File: tb/tb_shift_wb_stage.sv
// Directed bench for shift_wb_stage.
module tb_shift_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic        out_z;
  logic        out_n;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  shift_wb_stage #(.WIDTH(16), .RDW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_z      (out_z),
    .out_n      (out_n),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_result = 16'h0; in_rd = 4'h0; out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Zero result: 40>>>9 = 0, rd 3
    in_valid = 1'b1; in_result = 16'd0; in_rd = 4'd3;
    step();
    in_valid = 1'b0;
    chk("z_valid", 32'(out_valid), 32'd1);
    chk("z_result", 32'(out_result), 32'd0);
    chk("z_zflag", 32'(out_z), 32'd1);
    chk("z_nflag", 32'(out_n), 32'd0);
    chk("z_rd", 32'(out_rd), 32'd3);
    step();
    chk("z_drain_valid", 32'(out_valid), 32'd0);
    chk("z_drain_zflag", 32'(out_z), 32'd0);
    chk("z_drain_rd", 32'(out_rd), 32'd0);

    // Negative result: 16'hC000>>>4 = 16'hFC00
    in_valid = 1'b1; in_result = 16'hFC00; in_rd = 4'd5;
    step();
    in_valid = 1'b0;
    chk("n_valid", 32'(out_valid), 32'd1);
    chk("n_result", 32'(out_result), 32'hFC00);
    chk("n_nflag", 32'(out_n), 32'd1);
    chk("n_zflag", 32'(out_z), 32'd0);
    chk("n_rd", 32'(out_rd), 32'd5);
    step();
    chk("n_drain_valid", 32'(out_valid), 32'd0);
    chk("n_drain_result", 32'(out_result), 32'd0);
    chk("n_stall", 32'(stall_cnt), 32'd0);

    // Back-pressure: fill to two, stall counts, ordered release
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 16'h0001; in_rd = 4'd1;
    step();
    chk("bp1_valid", 32'(out_valid), 32'd1);
    chk("bp1_result", 32'(out_result), 32'h0001);
    chk("bp1_in_ready", 32'(in_ready), 32'd1);
    chk("bp1_stall", 32'(stall_cnt), 32'd0);
    in_result = 16'h0002; in_rd = 4'd2;
    step();
    chk("bp2_in_ready", 32'(in_ready), 32'd0);
    chk("bp2_result", 32'(out_result), 32'h0001);
    chk("bp2_stall", 32'(stall_cnt), 32'd1);
    in_result = 16'h0003; in_rd = 4'd7;
    step();
    chk("bp3_result", 32'(out_result), 32'h0001);
    chk("bp3_rd", 32'(out_rd), 32'd1);
    chk("bp3_stall", 32'(stall_cnt), 32'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp4_result", 32'(out_result), 32'h0002);
    chk("bp4_rd", 32'(out_rd), 32'd2);
    chk("bp4_in_ready", 32'(in_ready), 32'd1);
    chk("bp4_stall", 32'(stall_cnt), 32'd2);
    step();
    chk("bp5_valid", 32'(out_valid), 32'd0);
    chk("bp5_stall", 32'(stall_cnt), 32'd2);

    // Clear stall count, then stream at occupancy 1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("clr_stall", 32'(stall_cnt), 32'd0);
    in_valid = 1'b1; in_result = 16'd100; in_rd = 4'd0;
    step();
    chk("st_first", 32'(out_result), 32'd100);
    for (int i = 1; i <= 10; i++) begin
      in_result = 16'(100 + i); in_rd = 4'(i);
      step();
      chk("st_result", 32'(out_result), 32'(100 + i));
      chk("st_rd", 32'(out_rd), 32'(i & 15));
      chk("st_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("st_end_valid", 32'(out_valid), 32'd0);
    chk("st_stall", 32'(stall_cnt), 32'd0);

    // Flush at occupancy 2 beats a concurrent push
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 16'hAAAA;
    step();
    in_result = 16'hBBBB;
    step();
    chk("fl_in_ready_full", 32'(in_ready), 32'd0);
    flush = 1'b1; in_result = 16'hCCCC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_stall", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1;
    step();
    chk("fl_after_valid", 32'(out_valid), 32'd0);
    chk("fl_after_result", 32'(out_result), 32'd0);

    // Reset mid-operation at occupancy 1 with stall_cnt 5
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 16'h1234; in_rd = 4'd9;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("mr_valid_pre", 32'(out_valid), 32'd1);
    chk("mr_stall_pre", 32'(stall_cnt), 32'd5);
    rst_n = 1'b0;
    step();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_stall", 32'(stall_cnt), 32'd0);
    chk("mr_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("mr_no_wb_valid", 32'(out_valid), 32'd0);
    chk("mr_no_wb_result", 32'(out_result), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_wb_stage
